fat32_mount_sequencer: RTL
==========================

# fat32_mount_sequencer

Sequences the sector reads that mount a FAT32 volume on the SD card: it requests the MBR (sector 0), extracts the partition start (BPR sector), requests the BPR, computes the absolute root-directory sector, then scans root-directory sectors for the first free 32-byte directory entry. It sits between the SD block-read engine, which delivers one sector as an addressed byte stream, and the file-write logic, which consumes the root-directory location and the free-entry position.

## Interface
- `SECTOR_BYTES`, 512: bytes per sector; must equal 2^`ADDR_W`.
- `ADDR_W`, 9: byte-address width within a sector.
- `MAX_DIR_SECTORS`, 16: root-directory sectors scanned before failing; range 1..65535.

- `Clock` in 1: sole clock; all logic on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a mount; honoured only in IDLE, DONE or FAIL.
- `rd_req` out 1: sector-read request.
- `rd_sector` out 32: absolute sector number; stable while `rd_req`=1.
- `rd_ack` in 1: reader accepts the request.
- `byte_valid` in 1: `byte_addr` and `byte_data` are valid this cycle.
- `byte_addr` in `ADDR_W`: offset of the byte within the sector.
- `byte_data` in 8: byte value.
- `sector_done` in 1: one-cycle pulse after the last byte of the sector.
- `busy` out 1: high in every state except IDLE, DONE and FAIL.
- `mounted` out 1: level, high in DONE.
- `fail` out 1: level, high in FAIL.
- `fail_code` out 2: 1 = bad signature, 2 = zero FAT count or zero FAT length, 3 = no free entry.
- `bpr_sector` out 32: partition start sector.
- `root_sector` out 32: absolute root-directory sector.
- `free_sector` out 32: absolute sector that holds the free entry.
- `free_index` out 4: entry index inside `free_sector`, equal to byte offset / 32.

## Operation
- States: IDLE, REQ_MBR, RX_MBR, REQ_BPR, RX_BPR, CALC, REQ_DIR, RX_DIR, DONE, FAIL.
- IDLE/DONE/FAIL + `start`: all captured registers are cleared; go to REQ_MBR with `rd_sector`=0.
- REQ_x: `rd_req`=1. The state advances to RX_x in the cycle `rd_ack`=1 is sampled; `rd_req` is low in the following cycle.
- RX_MBR: bytes at 0x1C6..0x1C9 are captured little-endian into `bpr_sector`. On `sector_done`, go to REQ_BPR with `rd_sector`=`bpr_sector`. A value of 0 is legal: the BPR is then read from sector 0.
- RX_BPR: capture `reserved` from 0x0E..0x0F, `nfat` from 0x10, and `fatlen` from 0x24..0x27, all little-endian. On `sector_done`, go to CALC.
- CALC, one cycle: `root_sector` = `bpr_sector` + `reserved` + `nfat`×`fatlen`, truncated to 32 bits (modulo 2^32).
  - If `nfat`=0 or `fatlen`=0, go to FAIL with code 2.
  - Otherwise set the directory counter to 0 and go to REQ_DIR with `rd_sector`=`root_sector`+counter.
- RX_DIR: a byte with `byte_addr`[4:0]=0 and data 0x00 or 0xE5 marks a free entry. Only the first hit in the sector is latched, as `free_index`=`byte_addr`[8:5] and `free_sector`=`rd_sector`.
- On `sector_done` in RX_DIR:
  - hit latched: go to DONE;
  - no hit and counter+1 < `MAX_DIR_SECTORS`: increment the counter and go to REQ_DIR;
  - no hit otherwise: go to FAIL with code 3.
- `byte_valid` and `sector_done` are ignored outside RX states. A `sector_done` that arrives before all bytes have been seen is processed with whatever was captured.

## Timing
- Reset: state IDLE. `rd_req`, `busy`, `mounted`, `fail` = 0. `fail_code`, `bpr_sector`, `root_sector`, `free_sector`, `free_index`, `rd_sector` = 0.
- `start`→`rd_req` high: 1 cycle.
- Last `sector_done` of RX_BPR → `root_sector` valid: 2 cycles (CALC, then the next state).
- `sector_done` in the final RX_DIR → `mounted`=1 on the next cycle.
- `byte_valid` and `sector_done` in the same cycle: the byte is captured first, then the transition is evaluated.
- `start` while `busy`=1: ignored.
- `sys_rst_n` low mid-sequence: immediate return to the reset values. Any pending reader transaction is abandoned; the reader must be reset together with this block.
- `rd_ack` may arrive in the same cycle `rd_req` rises, or any number of cycles later. There is no timeout.

## Configuration
- `FAT32_SIG_CHECK_EN` defined:
  - RX_MBR and RX_BPR capture bytes 0x1FE and 0x1FF.
  - On `sector_done`, anything other than 0x55 and 0xAA sends the block to FAIL with code 1.
- Undefined: signatures are not checked, and code 1 never occurs.

## Test plan
- MBR with 0x1C6..9 = 00 20 00 00; BPR with reserved=0x0020, nfat=2, fatlen=0x000003C1; dir sector 0 with entry 3 byte 0 = 0x00 → `bpr_sector`=0x2000, `root_sector`=0x27A2, `free_sector`=0x27A2, `free_index`=3, `mounted`=1.
- Root sectors 0–1 full, sector 2 with entry 0 = 0xE5 → three dir reads at `rd_sector` 0x27A2, 0x27A3, 0x27A4; `free_index`=0.
- BPR nfat=0 → `fail`=1, `fail_code`=2, no directory request issued.
- All `MAX_DIR_SECTORS`=2 sectors full → `fail_code`=3 after exactly 2 dir reads.
- With `FAT32_SIG_CHECK_EN`: MBR byte 0x1FF=0x00 → `fail_code`=1. Without the macro, the same stimulus mounts normally.
- `sys_rst_n` pulsed low during RX_BPR → all outputs return to 0 asynchronously. A new `start` then reissues a sector-0 request.

Source files
------------

// File: rtl/fat32_mount_sequencer_if.sv
// Purpose : sector-read bus between the mount sequencer (master) and the SD block-read engine (slave).
// Latency : wires only, no storage.
// Backpressure: rd_req is held until rd_ack; the byte stream and sector_done have no backpressure.
// Signals : rd_req/rd_sector/rd_ack   - one sector-read request handshake
//           byte_valid/byte_addr/byte_data - addressed byte stream of the requested sector
//           sector_done                 - one-cycle pulse after the last byte
interface fat32_mount_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              rd_req;
  logic [31:0]       rd_sector;
  logic              rd_ack;
  logic              byte_valid;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0]        byte_data;
  logic              sector_done;

  modport master (
    output rd_req, rd_sector,
    input  rd_ack, byte_valid, byte_addr, byte_data, sector_done
  );

  modport slave (
    input  rd_req, rd_sector,
    output rd_ack, byte_valid, byte_addr, byte_data, sector_done
  );
endinterface

// File: rtl/fat32_mount_sequencer.sv
// Purpose : mounts a FAT32 volume: reads MBR, then BPR, computes the root-directory sector and
//           scans root-directory sectors for the first free 32-byte entry.
// Latency : start -> rd_req 1 cycle; last BPR sector_done -> root_sector 2 cycles;
//           final directory sector_done -> mounted/fail 1 cycle.
// Backpressure: waits indefinitely for rd_ack; byte stream is consumed at line rate.
// Ports   : Clock, sys_rst_n (async, active low), start pulse;
//           rd (master modport) - sector-read request and byte stream from the SD reader;
//           busy/mounted/fail/fail_code status; bpr_sector, root_sector, free_sector, free_index results.
// Option  : FAT32_SIG_CHECK_EN - check the 0x55 0xAA signature at the end of the MBR and BPR.
module fat32_mount_sequencer #(
  parameter int SECTOR_BYTES    = 512,
  parameter int ADDR_W          = 9,
  parameter int MAX_DIR_SECTORS = 16
) (
  input  logic                    Clock,
  input  logic                    sys_rst_n,
  input  logic                    start,
  fat32_mount_sequencer_if.master rd,
  output logic                    busy,
  output logic                    mounted,
  output logic                    fail,
  output logic [1:0]              fail_code,
  output logic [31:0]             bpr_sector,
  output logic [31:0]             root_sector,
  output logic [31:0]             free_sector,
  output logic [3:0]              free_index
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_MBR, S_RX_MBR, S_REQ_BPR, S_RX_BPR,
    S_CALC, S_REQ_DIR, S_RX_DIR, S_DONE, S_FAIL
  } state_t;

  // Byte offsets of the fields picked out of the MBR and BPR.
  localparam logic [ADDR_W-1:0] A_PART0  = ADDR_W'(16'h01C6);
  localparam logic [ADDR_W-1:0] A_PART1  = ADDR_W'(16'h01C7);
  localparam logic [ADDR_W-1:0] A_PART2  = ADDR_W'(16'h01C8);
  localparam logic [ADDR_W-1:0] A_PART3  = ADDR_W'(16'h01C9);
  localparam logic [ADDR_W-1:0] A_RSVD0  = ADDR_W'(16'h000E);
  localparam logic [ADDR_W-1:0] A_RSVD1  = ADDR_W'(16'h000F);
  localparam logic [ADDR_W-1:0] A_NFAT   = ADDR_W'(16'h0010);
  localparam logic [ADDR_W-1:0] A_FLEN0  = ADDR_W'(16'h0024);
  localparam logic [ADDR_W-1:0] A_FLEN1  = ADDR_W'(16'h0025);
  localparam logic [ADDR_W-1:0] A_FLEN2  = ADDR_W'(16'h0026);
  localparam logic [ADDR_W-1:0] A_FLEN3  = ADDR_W'(16'h0027);

  state_t      state_q, state_n;
  logic [31:0] bpr_n, root_n, fsec_n, rdsec_q, rdsec_n;
  logic [3:0]  fidx_n;
  logic [1:0]  code_n;
  logic [15:0] rsvd_q, rsvd_n;
  logic [7:0]  nfat_q, nfat_n;
  logic [31:0] flen_q, flen_n;
  logic [15:0] cnt_q, cnt_n;
  logic        hit_q, hit_n;
  logic        sig_ok;
  logic        free_byte;

`ifdef FAT32_SIG_CHECK_EN
  localparam logic [ADDR_W-1:0] A_SIG0 = ADDR_W'(SECTOR_BYTES - 2);
  localparam logic [ADDR_W-1:0] A_SIG1 = ADDR_W'(SECTOR_BYTES - 1);
  logic [7:0] sig0_q, sig0_n, sig1_q, sig1_n;
`else
  // SECTOR_BYTES only locates the signature bytes, which this build does not look at.
  logic unused_sector_bytes;
  assign unused_sector_bytes = ^SECTOR_BYTES;
`endif

  assign rd.rd_sector = rdsec_q;

  // A directory entry is free when its first byte is 0x00 (never used) or 0xE5 (deleted).
  assign free_byte = rd.byte_valid && (rd.byte_addr[4:0] == 5'd0) &&
                     ((rd.byte_data == 8'h00) || (rd.byte_data == 8'hE5));

  always_comb begin
    state_n = state_q;
    bpr_n   = bpr_sector;
    root_n  = root_sector;
    fsec_n  = free_sector;
    fidx_n  = free_index;
    code_n  = fail_code;
    rdsec_n = rdsec_q;
    rsvd_n  = rsvd_q;
    nfat_n  = nfat_q;
    flen_n  = flen_q;
    cnt_n   = cnt_q;
    hit_n   = hit_q;
    sig_ok  = 1'b1;
`ifdef FAT32_SIG_CHECK_EN
    sig0_n  = sig0_q;
    sig1_n  = sig1_q;
`endif

    rd.rd_req = (state_q == S_REQ_MBR) || (state_q == S_REQ_BPR) || (state_q == S_REQ_DIR);
    busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    mounted   = (state_q == S_DONE);
    fail      = (state_q == S_FAIL);

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          bpr_n   = '0;
          root_n  = '0;
          fsec_n  = '0;
          fidx_n  = '0;
          code_n  = '0;
          rdsec_n = '0;
          rsvd_n  = '0;
          nfat_n  = '0;
          flen_n  = '0;
          cnt_n   = '0;
          hit_n   = 1'b0;
`ifdef FAT32_SIG_CHECK_EN
          sig0_n  = '0;
          sig1_n  = '0;
`endif
          state_n = S_REQ_MBR;
        end
      end

      S_REQ_MBR: if (rd.rd_ack) state_n = S_RX_MBR;
      S_REQ_BPR: if (rd.rd_ack) state_n = S_RX_BPR;
      S_REQ_DIR: if (rd.rd_ack) state_n = S_RX_DIR;

      S_RX_MBR: begin
        if (rd.byte_valid) begin
          case (rd.byte_addr)
            A_PART0: bpr_n[7:0]   = rd.byte_data;
            A_PART1: bpr_n[15:8]  = rd.byte_data;
            A_PART2: bpr_n[23:16] = rd.byte_data;
            A_PART3: bpr_n[31:24] = rd.byte_data;
`ifdef FAT32_SIG_CHECK_EN
            A_SIG0:  sig0_n       = rd.byte_data;
            A_SIG1:  sig1_n       = rd.byte_data;
`endif
            default: ;
          endcase
        end
        // The _n values already include a byte arriving together with sector_done.
        if (rd.sector_done) begin
`ifdef FAT32_SIG_CHECK_EN
          sig_ok = (sig0_n == 8'h55) && (sig1_n == 8'hAA);
          // The BPR must present its own signature, not inherit the MBR's.
          sig0_n = '0;
          sig1_n = '0;
`endif
          if (!sig_ok) begin
            code_n  = 2'd1;
            state_n = S_FAIL;
          end else begin
            rdsec_n = bpr_n;
            state_n = S_REQ_BPR;
          end
        end
      end

      S_RX_BPR: begin
        if (rd.byte_valid) begin
          case (rd.byte_addr)
            A_RSVD0: rsvd_n[7:0]   = rd.byte_data;
            A_RSVD1: rsvd_n[15:8]  = rd.byte_data;
            A_NFAT:  nfat_n        = rd.byte_data;
            A_FLEN0: flen_n[7:0]   = rd.byte_data;
            A_FLEN1: flen_n[15:8]  = rd.byte_data;
            A_FLEN2: flen_n[23:16] = rd.byte_data;
            A_FLEN3: flen_n[31:24] = rd.byte_data;
`ifdef FAT32_SIG_CHECK_EN
            A_SIG0:  sig0_n        = rd.byte_data;
            A_SIG1:  sig1_n        = rd.byte_data;
`endif
            default: ;
          endcase
        end
        if (rd.sector_done) begin
`ifdef FAT32_SIG_CHECK_EN
          sig_ok = (sig0_n == 8'h55) && (sig1_n == 8'hAA);
`endif
          if (!sig_ok) begin
            code_n  = 2'd1;
            state_n = S_FAIL;
          end else begin
            state_n = S_CALC;
          end
        end
      end

      S_CALC: begin
        // Sum wraps modulo 2^32; the product is truncated to 32 bits as well.
        root_n = bpr_sector + 32'(rsvd_q) + (32'(nfat_q) * flen_q);
        if ((nfat_q == 8'd0) || (flen_q == 32'd0)) begin
          code_n  = 2'd2;
          state_n = S_FAIL;
        end else begin
          cnt_n   = '0;
          rdsec_n = root_n;
          state_n = S_REQ_DIR;
        end
      end

      S_RX_DIR: begin
        if (free_byte && !hit_q) begin
          hit_n  = 1'b1;
          fidx_n = 4'(rd.byte_addr[ADDR_W-1:5]);
          fsec_n = rdsec_q;
        end
        if (rd.sector_done) begin
          if (hit_n) begin
            state_n = S_DONE;
          end else if ((32'(cnt_q) + 32'd1) < 32'(MAX_DIR_SECTORS)) begin
            cnt_n   = cnt_q + 16'd1;
            rdsec_n = root_sector + 32'(cnt_q) + 32'd1;
            state_n = S_REQ_DIR;
          end else begin
            code_n  = 2'd3;
            state_n = S_FAIL;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      bpr_sector  <= '0;
      root_sector <= '0;
      free_sector <= '0;
      free_index  <= '0;
      fail_code   <= '0;
      rdsec_q     <= '0;
      rsvd_q      <= '0;
      nfat_q      <= '0;
      flen_q      <= '0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
`ifdef FAT32_SIG_CHECK_EN
      sig0_q      <= '0;
      sig1_q      <= '0;
`endif
    end else begin
      state_q     <= state_n;
      bpr_sector  <= bpr_n;
      root_sector <= root_n;
      free_sector <= fsec_n;
      free_index  <= fidx_n;
      fail_code   <= code_n;
      rdsec_q     <= rdsec_n;
      rsvd_q      <= rsvd_n;
      nfat_q      <= nfat_n;
      flen_q      <= flen_n;
      cnt_q       <= cnt_n;
      hit_q       <= hit_n;
`ifdef FAT32_SIG_CHECK_EN
      sig0_q      <= sig0_n;
      sig1_q      <= sig1_n;
`endif
    end
  end

endmodule
